// File: rtl/avalon_mem_responder.sv
// Avalon-MM memory responder: word RAM with byte-enabled writes and a fixed waitrequest stall.
// Optional random extra stall (0-3 cycles) via `define AVALON_MEM_RESPONDER_RANDOM_STALL_EN.
module avalon_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        protocol_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("LFSR_SEED must be non-zero");
    end

    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

    state_t      state, state_next;
    logic [4:0]  cnt;
    logic [4:0]  stall_len;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic        accept;
    logic        illegal;
    logic        drop;
    logic        capture;
    logic [31:0] addr_sel;
    logic [31:0] word_off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] mem [DEPTH_WORDS];

`ifdef AVALON_MEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign stall_len = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`else
    assign stall_len = 5'(WAIT_CYCLES);
`endif

    assign accept  = (state == IDLE) && (read ^ write);
    assign illegal = (state == IDLE) && read && write;
    assign drop    = (state == STALL) && !read && !write;

    // A zero-stall read goes IDLE->ACK directly, so decode the live address in IDLE.
    assign addr_sel = (state == IDLE) ? address : addr_q;
    assign word_off = (addr_sel - BASE_ADDR) >> 2;
    assign in_range = (addr_sel >= BASE_ADDR) && (word_off < DEPTH_WORDS);
    assign idx      = word_off[AW-1:0];

    always_comb begin
        state_next  = state;
        waitrequest = 1'b1;
        case (state)
            IDLE: begin
                waitrequest = read ^ write;
                if (read ^ write) begin
                    state_next = (stall_len != 5'd0) ? STALL : ACK;
                end
            end
            STALL: begin
                if (!read && !write) begin
                    state_next = IDLE;
                end else if (cnt == 5'd1) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                waitrequest = 1'b0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!rst_n) begin
            waitrequest = 1'b1;
        end
        capture = (state_next == ACK) && ((state == IDLE) ? read : !wr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            readdata     <= '0;
            protocol_err <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wr_q         <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= address;
                wdata_q <= writedata;
                be_q    <= byteenable;
                wr_q    <= write;
                cnt     <= stall_len;
            end else if (state == STALL) begin
                cnt <= cnt - 5'd1;
            end
            if (illegal || drop) begin
                protocol_err <= 1'b1;
            end
            if (capture) begin
                readdata <= in_range ? mem[idx] : '0;
            end
        end
    end

    // Commit on the edge leaving ACK; reset forces state to IDLE so a pending write is lost.
    always_ff @(posedge clk) begin
        if ((state == ACK) && wr_q && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed self-checking bench for avalon_mem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=3 instances).
module tb_avalon_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        sel3;

    logic        wr1, wr3, err1, err3;
    logic [31:0] rd1, rd3;
    logic        waitreq, perr;
    logic [31:0] rdata;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    avalon_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .address(address),
        .read(read & ~sel3), .write(write & ~sel3),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wr1), .readdata(rd1), .protocol_err(err1)
    );

    avalon_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .address(address),
        .read(read & sel3), .write(write & sel3),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wr3), .readdata(rd3), .protocol_err(err3)
    );

    assign waitreq = sel3 ? wr3 : wr1;
    assign rdata   = sel3 ? rd3 : rd1;
    assign perr    = sel3 ? err3 : err1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycles counted from request assertion to the waitrequest-low cycle inclusive.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int cyc, output logic [31:0] rd);
        @(negedge clk);
        address = a; writedata = d; byteenable = be;
        write = wr; read = !wr;
        cyc = 40; rd = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (waitreq === 1'b0) begin
                cyc = i + 1;
                rd  = rdata;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; read = 1'b1; write = 1'b0; sel3 = 1'b0;
        address = '0; writedata = '0; byteenable = '0;
        #2;
        vectors++;
        if (waitreq !== 1'b1) begin miscompares++; $display("FAIL reset_waitreq: got %b expected 1", waitreq); end
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata: got %h expected 00000000", rdata); end
        vectors++;
        if (perr !== 1'b0) begin miscompares++; $display("FAIL reset_perr: got %b expected 0", perr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; read = 1'b0;
        #1;
        vectors++;
        if (waitreq !== 1'b0) begin miscompares++; $display("FAIL reset_release_waitreq: got %b expected 0", waitreq); end
    endtask

    task automatic test_full_word;
        int cyc; logic [31:0] rd;
        xfer(1'b1, 32'h14, 32'hF987_6543, 4'hF, cyc, rd);
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL fw_write_latency: got %0d expected 3", cyc); end
        xfer(1'b0, 32'h14, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL fw_read_latency: got %0d expected 3", cyc); end
        vectors++;
        if (rd !== 32'hF987_6543) begin miscompares++; $display("FAIL fw_read_data: got %h expected f9876543", rd); end
        #1;
        vectors++;
        if (rdata !== 32'hF987_6543) begin miscompares++; $display("FAIL fw_readdata_hold: got %h expected f9876543", rdata); end
    endtask

    task automatic test_byte_lanes;
        int cyc; logic [31:0] rd;
        xfer(1'b1, 32'h10, 32'h0000_0000, 4'hF, cyc, rd);
        xfer(1'b1, 32'h10, 32'hAABB_CCDD, 4'b0110, cyc, rd);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h00BB_CC00) begin miscompares++; $display("FAIL be_0110: got %h expected 00bbcc00", rd); end
        xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, cyc, rd);
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL be_zero_latency: got %0d expected 3", cyc); end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h00BB_CC00) begin miscompares++; $display("FAIL be_zero_unchanged: got %h expected 00bbcc00", rd); end
    endtask

    task automatic test_misaligned_range;
        int cyc; logic [31:0] rd;
        xfer(1'b0, 32'h13, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h00BB_CC00) begin miscompares++; $display("FAIL misaligned_read: got %h expected 00bbcc00", rd); end
        xfer(1'b0, 32'h100, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL oor_read: got %h expected 00000000", rd); end
        xfer(1'b1, 32'h0, 32'h1111_1111, 4'hF, cyc, rd);
        xfer(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, cyc, rd);
        vectors++;
        if (cyc !== 3) begin miscompares++; $display("FAIL oor_write_latency: got %0d expected 3", cyc); end
        xfer(1'b0, 32'h0, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h1111_1111) begin miscompares++; $display("FAIL oor_write_alias: got %h expected 11111111", rd); end
    endtask

    task automatic test_illegal;
        int cyc; logic [31:0] rd;
        @(negedge clk);
        address = 32'h10; writedata = 32'h0; byteenable = 4'hF;
        read = 1'b1; write = 1'b1;
        #1;
        vectors++;
        if (waitreq !== 1'b0) begin miscompares++; $display("FAIL rw_waitreq: got %b expected 0", waitreq); end
        @(negedge clk);
        #1;
        vectors++;
        if (perr !== 1'b1) begin miscompares++; $display("FAIL rw_perr: got %b expected 1", perr); end
        read = 1'b0; write = 1'b0;
        xfer(1'b0, 32'h10, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h00BB_CC00) begin miscompares++; $display("FAIL rw_mem_unchanged: got %h expected 00bbcc00", rd); end

        // Drop a write during the single STALL cycle of the WAIT_CYCLES=1 instance.
        @(negedge clk);
        address = 32'h10; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (waitreq !== 1'b0) begin miscompares++; $display("FAIL drop1_idle: got %b expected 0", waitreq); end
        vectors++;
        if (perr !== 1'b1) begin miscompares++; $display("FAIL drop1_perr_sticky: got %b expected 1", perr); end
        xfer(1'b0, 32'h10, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h00BB_CC00) begin miscompares++; $display("FAIL drop1_mem: got %h expected 00bbcc00", rd); end

        // WAIT_CYCLES=3 instance: latency check, then drop after two STALL cycles.
        sel3 = 1'b1;
        xfer(1'b1, 32'h20, 32'h1234_5678, 4'hF, cyc, rd);
        vectors++;
        if (cyc !== 5) begin miscompares++; $display("FAIL w3_latency: got %0d expected 5", cyc); end
        vectors++;
        if (perr !== 1'b0) begin miscompares++; $display("FAIL w3_perr_clear: got %b expected 0", perr); end
        @(negedge clk);
        address = 32'h20; writedata = 32'h0; byteenable = 4'hF; write = 1'b1;
        repeat (2) @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (waitreq !== 1'b0) begin miscompares++; $display("FAIL drop3_idle: got %b expected 0", waitreq); end
        vectors++;
        if (perr !== 1'b1) begin miscompares++; $display("FAIL drop3_perr: got %b expected 1", perr); end
        xfer(1'b0, 32'h20, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL drop3_mem: got %h expected 12345678", rd); end
        sel3 = 1'b0;
    endtask

    task automatic test_reset_mid_write;
        int cyc; logic [31:0] rd;
        xfer(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, cyc, rd);
        @(negedge clk);
        address = 32'h20; writedata = 32'h0; byteenable = 4'hF; write = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (waitreq !== 1'b1) begin miscompares++; $display("FAIL rst_mid_waitreq: got %b expected 1", waitreq); end
        vectors++;
        if (perr !== 1'b0) begin miscompares++; $display("FAIL rst_mid_perr: got %b expected 0", perr); end
        @(negedge clk);
        rst_n = 1'b1; write = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (waitreq !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle: got %b expected 0", waitreq); end
        xfer(1'b0, 32'h20, 32'h0, 4'h0, cyc, rd);
        vectors++;
        if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rst_mid_mem: got %h expected cafef00d", rd); end
    endtask

`ifdef AVALON_MEM_RESPONDER_RANDOM_STALL_EN
    task automatic test_random_stall;
        int cyc; logic [31:0] rd;
        for (int i = 0; i < 20; i++) begin
            xfer(1'b0, 32'h20, 32'h0, 4'h0, cyc, rd);
            vectors++;
            if (cyc < 3 || cyc > 6) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected 3..6", i, cyc); end
            vectors++;
            if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected cafef00d", i, rd); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_full_word;
        test_byte_lanes;
        test_misaligned_range;
        test_illegal;
        test_reset_mid_write;
`ifdef AVALON_MEM_RESPONDER_RANDOM_STALL_EN
        test_random_stall;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
